// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and uart_hello state encoding
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_BAUD_RATE  = 921600;
  localparam int UART_STOP_BITS  = 1;
  localparam int UART_PARITY     = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/uart_hello.sv
// rtl/uart_hello.sv - streams the fixed message C_MSG into a uart_tx send/busy handshake
module uart_hello
  import uart_pkg::*;
#(
  parameter int C_UART_DATA_WIDTH = UART_DATA_WIDTH,
  parameter int C_MSG_LEN         = 5,
  parameter logic [C_UART_DATA_WIDTH*((C_MSG_LEN > 0) ? C_MSG_LEN : 1)-1:0] C_MSG = "12345"
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         send,
  output logic                         busy,
  input  logic                         txBusy,
  output logic                         txSend,
  output logic [C_UART_DATA_WIDTH-1:0] txData,
  input  logic                         txErr
);

  localparam int W     = C_UART_DATA_WIDTH;
  localparam int SLOTS = (C_MSG_LEN > 0) ? C_MSG_LEN : 1;
  localparam int IDX_W = (C_MSG_LEN > 0) ? $clog2(C_MSG_LEN + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;

  // First character lives in the MSBs of the packed message.
  function automatic logic [W-1:0] charAt(input logic [IDX_W-1:0] i);
    logic [W*SLOTS-1:0] shifted;
    shifted = C_MSG >> (W * (SLOTS - 1 - int'(i)));
    return shifted[W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rstb) begin
      state  <= S_IDLE;
      idx    <= '0;
      busy   <= 1'b0;
      txSend <= 1'b0;
      txData <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (send) begin
            busy <= 1'b1;
            if (C_MSG_LEN > 0) begin
              state  <= S_REQ;
              idx    <= '0;
              txData <= charAt('0);
              txSend <= 1'b1;
            end else begin
              state <= S_DONE;
            end
          end
        end
        // txSend stays up until the Tx shows busy, even if busy was already high.
        S_REQ: begin
          if (txErr) begin
            state  <= S_IDLE;
            txSend <= 1'b0;
            busy   <= 1'b0;
          end else if (txBusy) begin
            state  <= S_HOLD;
            txSend <= 1'b0;
          end
        end
        S_HOLD: begin
          if (txErr) begin
            state  <= S_IDLE;
            txSend <= 1'b0;
            busy   <= 1'b0;
          end else if (!txBusy) begin
            if (idx < LAST_IDX) begin
              state  <= S_REQ;
              idx    <= idx + IDX_W'(1);
              txData <= charAt(idx + IDX_W'(1));
              txSend <= 1'b1;
            end else begin
              state <= S_DONE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hello.sv
// tb/tb_uart_hello.sv - directed self-checking bench for uart_hello with a behavioural Tx model
module tb_uart_hello;
  localparam int W       = 8;
  localparam int TX_DLY  = 2;
  localparam int TX_HOLD = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstb, send, busy, txBusy, txSend, txErr;
  logic [W-1:0] txData;
  logic send0, busy0, txBusy0, txSend0, txErr0;
  logic [W-1:0] txData0;
  logic send1, busy1, txBusy1, txSend1, txErr1;
  logic [W-1:0] txData1;

  uart_hello #(.C_UART_DATA_WIDTH(W), .C_MSG_LEN(5), .C_MSG("12345")) dut (
    .clk(clk), .rstb(rstb), .send(send), .busy(busy), .txBusy(txBusy),
    .txSend(txSend), .txData(txData), .txErr(txErr));

  uart_hello #(.C_UART_DATA_WIDTH(W), .C_MSG_LEN(0), .C_MSG(8'h00)) dut0 (
    .clk(clk), .rstb(rstb), .send(send0), .busy(busy0), .txBusy(txBusy0),
    .txSend(txSend0), .txData(txData0), .txErr(txErr0));

  uart_hello #(.C_UART_DATA_WIDTH(W), .C_MSG_LEN(1), .C_MSG("A")) dut1 (
    .clk(clk), .rstb(rstb), .send(send1), .busy(busy1), .txBusy(txBusy1),
    .txSend(txSend1), .txData(txData1), .txErr(txErr1));

  int passCnt = 0;
  int totalCnt = 0;
  int cyc = 0, sendRises = 0, stabErr = 0, hsErr = 0, lastBusyFall = 0;
  int sends0 = 0, rises1 = 0;
  logic [W-1:0] rxQ[$];
  logic prevSend = 1'b0, prevBusy = 1'b0, prevSend1 = 1'b0;
  logic [W-1:0] prevData = '0;

  // Tx model plus handshake monitor, updated on every falling edge.
  initial begin : txModel
    int dly, hold;
    txBusy = 1'b0;
    dly = 0;
    hold = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (txSend && !prevSend) sendRises++;
      if (txSend && prevSend && txData !== prevData) stabErr++;
      if (prevSend && prevBusy && txSend) hsErr++;
      if (txSend0) sends0++;
      if (txSend1 && !prevSend1) rises1++;
      if (rstb) begin
        txBusy = 1'b0;
        dly = 0;
        hold = 0;
      end else if (txBusy) begin
        if (hold >= TX_HOLD) begin
          txBusy = 1'b0;
          lastBusyFall = cyc;
          hold = 0;
        end else hold++;
      end else if (txSend) begin
        if (dly >= TX_DLY) begin
          txBusy = 1'b1;
          rxQ.push_back(txData);
          dly = 0;
        end else dly++;
      end
      prevSend = txSend;
      prevBusy = txBusy;
      prevData = txData;
      prevSend1 = txSend1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    totalCnt++;
    if (busy !== 1'b0) $display("FAIL %s: timeout busy=%b required 0", name, busy);
    else passCnt++;
  endtask

  task automatic waitChars(input int count, input string name);
    int n;
    n = 0;
    while (rxQ.size() < count && n < 2000) begin
      tick();
      n++;
    end
    totalCnt++;
    if (rxQ.size() < count) $display("FAIL %s: timeout chars=%0d required %0d", name, rxQ.size(), count);
    else passCnt++;
  endtask

  task automatic test_reset();
    rstb = 1'b1;
    send = 1'b1; send0 = 1'b1; send1 = 1'b1;
    txErr = 1'b0; txErr0 = 1'b0; txErr1 = 1'b0;
    txBusy0 = 1'b0; txBusy1 = 1'b0;
    repeat (10) tick();
    totalCnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passCnt++;
    totalCnt++; if (txSend !== 1'b0) $display("FAIL reset_txSend: got %b required 0", txSend); else passCnt++;
    totalCnt++; if (txData !== 8'h00) $display("FAIL reset_txData: got %h required 00", txData); else passCnt++;
    totalCnt++; if (busy0 !== 1'b0) $display("FAIL reset_busy0: got %b required 0", busy0); else passCnt++;
    totalCnt++; if (busy1 !== 1'b0) $display("FAIL reset_busy1: got %b required 0", busy1); else passCnt++;
    totalCnt++; if (txData1 !== 8'h00) $display("FAIL reset_txData1: got %h required 00", txData1); else passCnt++;
    send = 1'b0; send0 = 1'b0; send1 = 1'b0;
    rstb = 1'b0;
    tick();
    totalCnt++; if (busy !== 1'b0) $display("FAIL reset_no_start: got %b required 0", busy); else passCnt++;
  endtask

  task automatic test_message();
    logic [W-1:0] exp;
    rxQ.delete();
    sendRises = 0; stabErr = 0; hsErr = 0;
    send = 1'b1;
    tick();
    send = 1'b0;
    totalCnt++; if (busy !== 1'b1) $display("FAIL msg_latency_busy: got %b required 1", busy); else passCnt++;
    totalCnt++; if (txSend !== 1'b1) $display("FAIL msg_latency_txSend: got %b required 1", txSend); else passCnt++;
    totalCnt++; if (txData !== 8'h31) $display("FAIL msg_first_char: got %h required 31", txData); else passCnt++;
    waitIdle("msg_done");
    totalCnt++;
    if (cyc - lastBusyFall != 2) $display("FAIL msg_busy_fall: got %0d cycles required 2", cyc - lastBusyFall);
    else passCnt++;
    totalCnt++; if (rxQ.size() != 5) $display("FAIL msg_count: got %0d required 5", rxQ.size()); else passCnt++;
    for (int i = 0; i < rxQ.size(); i++) begin
      exp = 8'h31 + 8'(i);
      totalCnt++;
      if (rxQ[i] !== exp) $display("FAIL msg_char%0d: got %h required %h", i, rxQ[i], exp);
      else passCnt++;
    end
    totalCnt++; if (sendRises != 5) $display("FAIL msg_send_rises: got %0d required 5", sendRises); else passCnt++;
  endtask

  task automatic test_handshake();
    totalCnt++; if (stabErr != 0) $display("FAIL hs_data_stable: got %0d changes required 0", stabErr); else passCnt++;
    totalCnt++; if (hsErr != 0) $display("FAIL hs_send_drop: got %0d late drops required 0", hsErr); else passCnt++;
  endtask

  task automatic test_abort();
    rxQ.delete();
    sendRises = 0;
    send = 1'b1;
    tick();
    send = 1'b0;
    waitChars(3, "abort_reach_char3");
    txErr = 1'b1;
    tick();
    txErr = 1'b0;
    totalCnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b required 0", busy); else passCnt++;
    totalCnt++; if (txSend !== 1'b0) $display("FAIL abort_txSend: got %b required 0", txSend); else passCnt++;
    repeat (60) tick();
    totalCnt++; if (rxQ.size() != 3) $display("FAIL abort_no_more: got %0d chars required 3", rxQ.size()); else passCnt++;
    totalCnt++; if (sendRises != 3) $display("FAIL abort_rises: got %0d required 3", sendRises); else passCnt++;
    rxQ.delete();
    send = 1'b1;
    tick();
    send = 1'b0;
    waitIdle("abort_restart_done");
    totalCnt++; if (rxQ.size() != 5) $display("FAIL abort_restart_count: got %0d required 5", rxQ.size()); else passCnt++;
    totalCnt++;
    if (rxQ.size() == 0 || rxQ[0] !== 8'h31) $display("FAIL abort_restart_first: got %h required 31", (rxQ.size() > 0) ? rxQ[0] : 8'hxx);
    else passCnt++;
  endtask

  task automatic test_ignore();
    rxQ.delete();
    sendRises = 0;
    send = 1'b1;
    tick();
    send = 1'b0;
    waitChars(2, "ignore_reach_char2");
    send = 1'b1;
    tick();
    send = 1'b0;
    waitChars(4, "ignore_reach_char4");
    repeat (2) tick();
    send = 1'b1;
    tick();
    send = 1'b0;
    waitIdle("ignore_done");
    repeat (40) tick();
    totalCnt++; if (rxQ.size() != 5) $display("FAIL ignore_count: got %0d required 5", rxQ.size()); else passCnt++;
    totalCnt++; if (sendRises != 5) $display("FAIL ignore_rises: got %0d required 5", sendRises); else passCnt++;
    totalCnt++; if (busy !== 1'b0) $display("FAIL ignore_idle: got %b required 0", busy); else passCnt++;
  endtask

  task automatic test_back_to_back();
    int lowTicks, n;
    logic [W-1:0] exp;
    rxQ.delete();
    lowTicks = 0;
    n = 0;
    send = 1'b1;
    tick();
    while (rxQ.size() < 10 && n < 3000) begin
      if (busy === 1'b0) lowTicks++;
      tick();
      n++;
    end
    send = 1'b0;
    waitIdle("b2b_done");
    totalCnt++; if (lowTicks != 1) $display("FAIL b2b_gap: got %0d idle cycles required 1", lowTicks); else passCnt++;
    totalCnt++; if (rxQ.size() != 10) $display("FAIL b2b_count: got %0d required 10", rxQ.size()); else passCnt++;
    for (int i = 0; i < rxQ.size(); i++) begin
      exp = 8'h31 + 8'(i % 5);
      totalCnt++;
      if (rxQ[i] !== exp) $display("FAIL b2b_char%0d: got %h required %h", i, rxQ[i], exp);
      else passCnt++;
    end
  endtask

  task automatic test_edge();
    send0 = 1'b1;
    tick();
    send0 = 1'b0;
    totalCnt++; if (busy0 !== 1'b1) $display("FAIL len0_busy_high: got %b required 1", busy0); else passCnt++;
    tick();
    totalCnt++; if (busy0 !== 1'b0) $display("FAIL len0_busy_low: got %b required 0", busy0); else passCnt++;
    totalCnt++; if (sends0 != 0) $display("FAIL len0_no_txSend: got %0d required 0", sends0); else passCnt++;

    send1 = 1'b1;
    tick();
    send1 = 1'b0;
    totalCnt++; if (txSend1 !== 1'b1) $display("FAIL len1_txSend: got %b required 1", txSend1); else passCnt++;
    totalCnt++; if (txData1 !== 8'h41) $display("FAIL len1_char: got %h required 41", txData1); else passCnt++;
    txBusy1 = 1'b1;
    tick();
    totalCnt++; if (txSend1 !== 1'b0) $display("FAIL len1_send_drop: got %b required 0", txSend1); else passCnt++;
    txBusy1 = 1'b0;
    tick();
    totalCnt++; if (busy1 !== 1'b1) $display("FAIL len1_done_busy: got %b required 1", busy1); else passCnt++;
    tick();
    totalCnt++; if (busy1 !== 1'b0) $display("FAIL len1_idle: got %b required 0", busy1); else passCnt++;
    repeat (5) tick();
    totalCnt++; if (rises1 != 1) $display("FAIL len1_rises: got %0d required 1", rises1); else passCnt++;

    send = 1'b1;
    tick();
    send = 1'b0;
    waitChars(1, "rst_mid_reach");
    repeat (3) tick();
    rstb = 1'b1;
    tick();
    rstb = 1'b0;
    totalCnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b required 0", busy); else passCnt++;
    totalCnt++; if (txSend !== 1'b0) $display("FAIL rst_mid_txSend: got %b required 0", txSend); else passCnt++;
    totalCnt++; if (txData !== 8'h00) $display("FAIL rst_mid_txData: got %h required 00", txData); else passCnt++;
    tick();
    totalCnt++; if (busy !== 1'b0) $display("FAIL rst_mid_stay_idle: got %b required 0", busy); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_message();
    test_handshake();
    test_abort();
    test_ignore();
    test_back_to_back();
    test_edge();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
